// File: rtl/timer_compare.sv
// Compare timer: raises an interrupt when the free-running cycle count reaches
// a programmed deadline, in one-shot or periodic mode, with match-time capture.
module timer_compare (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] count_i,
   input  logic        sel_i,
   input  logic        we_i,
   input  logic [1:0]  addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        irq_o
);

   localparam int unsigned W = 32;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PERIOD = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_SNAP   = 2'd3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ARMED = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic           en_q, en_d;
   logic           periodic_q, periodic_d;
   logic           ie_q, ie_d;
   logic [W-1:0]   period_q, period_d;
   logic           pending_q, pending_d;
   logic [W-1:0]   snap_q, snap_d;
   logic [W-1:0]   deadline_q, deadline_d;
   logic           irq_q, irq_d;

   logic           ctrl_wr;
   logic           period_wr;
   logic           status_wr;
   logic           match;

   // A zero period behaves as a one-cycle period.
   function automatic logic [W-1:0] peff(input logic [W-1:0] p);
      return (p == '0) ? W'(1) : p;
   endfunction

   assign ctrl_wr   = sel_i && we_i && (addr_i == ADDR_CTRL);
   assign period_wr = sel_i && we_i && (addr_i == ADDR_PERIOD);
   assign status_wr = sel_i && we_i && (addr_i == ADDR_STATUS);
   assign match     = (state_q == ST_ARMED) && (count_i == deadline_q);

   // Next-state: clear first, then match, then bus writes, so later steps win.
   always_comb begin
      state_d    = state_q;
      en_d       = en_q;
      periodic_d = periodic_q;
      ie_d       = ie_q;
      period_d   = period_q;
      pending_d  = pending_q;
      snap_d     = snap_q;
      deadline_d = deadline_q;

      if (status_wr && data_i[0]) begin
         pending_d = 1'b0;
      end

      if (match) begin
         pending_d = 1'b1;
         snap_d    = count_i;
         if (periodic_q) begin
            deadline_d = deadline_q + peff(period_q);
         end else begin
            en_d    = 1'b0;
            state_d = ST_IDLE;
         end
      end

      if (ctrl_wr) begin
         en_d       = data_i[0];
         periodic_d = data_i[1];
         ie_d       = data_i[2];
         if (data_i[0]) begin
            state_d    = ST_ARMED;
            deadline_d = count_i + peff(period_q);
         end else begin
            state_d = ST_IDLE;
         end
      end

      if (period_wr) begin
         period_d = data_i;
         if (state_q == ST_ARMED) begin
            state_d    = ST_ARMED;
            en_d       = 1'b1;
            deadline_d = count_i + peff(data_i);
         end
      end

      irq_d = pending_d & ie_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         en_q       <= 1'b0;
         periodic_q <= 1'b0;
         ie_q       <= 1'b0;
         period_q   <= '0;
         pending_q  <= 1'b0;
         snap_q     <= '0;
         deadline_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         en_q       <= en_d;
         periodic_q <= periodic_d;
         ie_q       <= ie_d;
         period_q   <= period_d;
         pending_q  <= pending_d;
         snap_q     <= snap_d;
         deadline_q <= deadline_d;
         irq_q      <= irq_d;
      end
   end

   assign irq_o = irq_q;

   // Zero-wait read mux.
   always_comb begin
      data_o = '0;
      if (sel_i) begin
         case (addr_i)
            ADDR_CTRL:   data_o = {29'd0, ie_q, periodic_q, en_q};
            ADDR_PERIOD: data_o = period_q;
            ADDR_STATUS: data_o = {31'd0, pending_q};
            ADDR_SNAP:   data_o = snap_q;
            default:     data_o = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_timer_compare.sv
// Directed bench for timer_compare: a vector table for the one-shot flow plus
// hand sequences for periodic, wrap, collision, edge-config and reset cases.
module tb_timer_compare;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] count_i = '0;
   logic        sel_i = 1'b0;
   logic        we_i = 1'b0;
   logic [1:0]  addr_i = '0;
   logic [31:0] data_i = '0;
   logic [31:0] data_o;
   logic        irq_o;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] cnt = 32'd96;

   timer_compare dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .count_i (count_i),
      .sel_i   (sel_i),
      .we_i    (we_i),
      .addr_i  (addr_i),
      .data_i  (data_i),
      .data_o  (data_o),
      .irq_o   (irq_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rst;
      logic        sel;
      logic        we;
      logic [1:0]  addr;
      logic [31:0] wdata;
      int          n;
      logic [31:0] exp_data;
      logic        exp_irq;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic s, input logic w, input logic [1:0] a,
                      input logic [31:0] d, input int n, input logic [31:0] ed,
                      input logic ei);
      vec_t v;
      v.rst = r; v.sel = s; v.we = w; v.addr = a; v.wdata = d;
      v.n = n; v.exp_data = ed; v.exp_irq = ei;
      tbl.push_back(v);
   endtask

   // One bus cycle: inputs change at negedge, count_i follows the bench counter.
   task automatic drive(input logic r, input logic s, input logic w, input logic [1:0] a,
                        input logic [31:0] d);
      @(negedge clk_i);
      rst_i = r; sel_i = s; we_i = w; addr_i = a; data_i = d;
      count_i = cnt;
      cnt = cnt + 32'd1;
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (count_i=0x%08h)",
                  name, act, exp, count_i);
      end
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      drive(1'b0, 1'b1, 1'b1, a, d);
   endtask

   task automatic rc(input string name, input logic [1:0] a, input logic [31:0] ed,
                     input logic ei);
      drive(1'b0, 1'b1, 1'b0, a, 32'd0);
      chk({name, " data"}, data_o, ed);
      chk({name, " irq"}, 32'(irq_o), 32'(ei));
   endtask

   task automatic ci(input string name, input logic ei);
      chk({name, " irq"}, 32'(irq_o), 32'(ei));
   endtask

   task automatic do_reset(input logic [31:0] c);
      cnt = c;
      drive(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
   endtask

   initial begin
      // One-shot, IE=1, PERIOD=10 armed at count 100; rows start at count 96.
      add(1, 0, 0, 0, 0,         1,  0,   0); // 96 reset
      add(0, 1, 0, 0, 0,         1,  0,   0); // 97 CTRL after reset
      add(0, 1, 1, 1, 10,        1,  0,   0); // 98 write PERIOD, old value read
      add(0, 1, 0, 1, 0,         1,  10,  0); // 99
      add(0, 1, 1, 0, 5,         1,  0,   0); // 100 arm
      add(0, 1, 0, 0, 0,         1,  5,   0); // 101
      add(0, 1, 0, 2, 0,         8,  0,   0); // 102..109
      add(0, 1, 0, 2, 0,         1,  0,   0); // 110 match cycle
      add(0, 1, 0, 2, 0,         1,  1,   1); // 111
      add(0, 1, 0, 3, 0,         1,  110, 1); // 112 SNAP
      add(0, 1, 0, 0, 0,         1,  4,   1); // 113 EN cleared
      add(0, 1, 1, 2, 1,         1,  1,   1); // 114 W1C
      add(0, 1, 0, 2, 0,         1,  0,   0); // 115
      add(0, 0, 1, 1, 32'h55,    1,  0,   0); // 116 unselected write
      add(0, 1, 0, 1, 0,         1,  10,  0); // 117 PERIOD unchanged
      add(0, 1, 0, 2, 0,         20, 0,   0); // 118..137 no re-fire

      foreach (tbl[i]) begin
         for (int k = 0; k < tbl[i].n; k++) begin
            drive(tbl[i].rst, tbl[i].sel, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            chk($sformatf("vec%0d.%0d data", i, k), data_o, tbl[i].exp_data);
            chk($sformatf("vec%0d.%0d irq", i, k), 32'(irq_o), 32'(tbl[i].exp_irq));
         end
      end

      // Periodic PERIOD=4 armed at count 0: matches at 4, 8, 12, 16, 20.
      do_reset(32'hFFFF_FFFE);
      wr(2'd1, 32'd4);
      wr(2'd0, 32'd7);
      idle(); idle(); idle();
      rc("per first", 2'd2, 0, 1'b0);
      for (int m = 1; m <= 4; m++) begin
         rc($sformatf("per snap%0d", m), 2'd3, 32'(4 * m), 1'b1);
         wr(2'd2, 32'd1);
         ci($sformatf("per w1c%0d", m), 1'b1);
         rc($sformatf("per clr%0d", m), 2'd2, 0, 1'b0);
         rc($sformatf("per pre%0d", m), 2'd2, 0, 1'b0);
      end
      wr(2'd0, 32'd0);
      ci("per dis", 1'b1);
      rc("ie0 pend", 2'd2, 1, 1'b0);
      wr(2'd0, 32'd4);
      ci("ie set", 1'b0);
      rc("ie1 irq", 2'd0, 4, 1'b1);
      wr(2'd2, 32'd1);
      rc("ie1 clr", 2'd2, 0, 1'b0);

      // Wrap-around: PERIOD=8 armed at 0xFFFFFFFC, match at 4.
      do_reset(32'hFFFF_FFFA);
      wr(2'd1, 32'd8);
      wr(2'd0, 32'd5);
      for (int k = 0; k < 8; k++) rc($sformatf("wrap wait%0d", k), 2'd2, 0, 1'b0);
      rc("wrap snap", 2'd3, 4, 1'b1);
      rc("wrap ctrl", 2'd0, 4, 1'b1);

      // Collisions: W1C and EN=0 each land on a match cycle.
      do_reset(32'd998);
      wr(2'd1, 32'd3);
      wr(2'd0, 32'd7);
      idle(); idle();
      wr(2'd2, 32'd1);
      rc("col w1c", 2'd2, 1, 1'b1);
      wr(2'd2, 32'd1);
      ci("col clr", 1'b1);
      wr(2'd0, 32'd4);
      ci("col en0 cyc", 1'b0);
      rc("col en0 pend", 2'd2, 1, 1'b1);
      rc("col en0 snap", 2'd3, 1006, 1'b1);
      rc("col en0 ctrl", 2'd0, 4, 1'b1);
      wr(2'd2, 32'd1);
      for (int k = 0; k < 6; k++) rc($sformatf("col idle%0d", k), 2'd2, 0, 1'b0);

      // PERIOD=0 behaves as one cycle.
      do_reset(32'd48);
      idle();
      wr(2'd0, 32'd5);
      rc("p0 match", 2'd2, 0, 1'b0);
      rc("p0 snap", 2'd3, 51, 1'b1);

      // PERIOD write while armed re-arms from the current count.
      wr(2'd2, 32'd1);
      wr(2'd1, 32'd10);
      wr(2'd0, 32'd5);
      idle(); idle(); idle(); idle();
      wr(2'd1, 32'd3);
      for (int k = 0; k < 3; k++) rc($sformatf("rearm wait%0d", k), 2'd2, 0, 1'b0);
      rc("rearm snap", 2'd3, 63, 1'b1);

      // Reset three cycles before a match, with an interrupt already pending.
      wr(2'd1, 32'd10);
      wr(2'd0, 32'd5);
      for (int k = 0; k < 6; k++) idle();
      drive(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
      ci("rst before", 1'b1);
      for (int a = 0; a < 4; a++) rc($sformatf("rst reg%0d", a), 2'(a), 0, 1'b0);
      for (int k = 0; k < 4; k++) rc($sformatf("rst idle%0d", k), 2'd2, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/timer_compare.md
# timer_compare

Memory-mapped compare timer that consumes the free-running 32-bit cycle count and raises an interrupt when a programmed number of cycles has elapsed. Sits on the processor's peripheral bus next to the cycle counter and takes that counter's raw value as its time base. Supports one-shot and periodic modes, captures the count at each match, and exposes pending/enable state to software.

## Interface
- No parameters; all widths fixed at 32 bits.
- clk_i  in  1  system clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- count_i  in  32  free-running cycle count; increments by exactly 1 every clk_i cycle and wraps modulo 2^32.
- sel_i  in  1  peripheral select from the address decoder.
- we_i  in  1  write strobe; acts only when sel_i=1.
- addr_i  in  2  register index.
- data_i  in  32  write data.
- data_o  out  32  read data; combinational; 0 when sel_i=0.
- irq_o  out  1  interrupt request, level, active-high.

## Operation
- Register map:
  - 0 CTRL: bit0 EN, bit1 PERIODIC, bit2 IE; bits 31:3 read 0.
  - 1 PERIOD: cycle delta.
  - 2 STATUS: bit0 PENDING; write 1 to clear, write 0 has no effect.
  - 3 SNAP: read-only count_i captured at the last match; writes ignored.
- Reset values: CTRL=0, PERIOD=0, PENDING=0, SNAP=0, deadline=0, state=IDLE, irq_o=0, data_o=0.
- Effective period: Peff = (PERIOD==0) ? 1 : PERIOD.
- State machine:
  - IDLE: no compare.
    - CTRL write with EN=1: deadline <= count_i + Peff (mod 2^32), then ARMED.
  - ARMED: compare count_i == deadline each cycle.
    - On match: PENDING <= 1 and SNAP <= count_i.
      - PERIODIC=1: deadline <= deadline + Peff, stay ARMED.
      - PERIODIC=0: clear EN, go to IDLE.
    - CTRL write with EN=0: go to IDLE. PENDING and SNAP are kept.
    - CTRL write with EN=1 while ARMED: re-arm with deadline <= count_i + Peff.
    - PERIOD write while ARMED: stores the new value and re-arms with deadline <= count_i + new Peff.
- irq_o = PENDING & IE. It is taken from registers, so it has no combinational path from the bus.
- Arithmetic: all additions are 32-bit and truncating. Matching uses equality only, so wrap-around needs no special case.
- Simultaneous events:
  - Match and STATUS W1C in the same cycle: set wins, PENDING stays 1.
  - Match and CTRL EN=0 write in the same cycle: the match is recorded (PENDING=1, SNAP updated), then IDLE.
  - Match and CTRL/PERIOD re-arm write in the same cycle: the match is recorded, and the write's new deadline wins.
- Reset asserted mid-operation: all state returns to its reset value on that edge, regardless of bus activity.

## Timing
- Register writes take effect on the clk_i edge that ends the write cycle. Readback of the new value starts in the next cycle.
- Arming write in cycle t, when count_i = C: deadline = C+Peff, and the match cycle is t+Peff.
- PENDING and SNAP update on the edge that ends the match cycle. irq_o is asserted from cycle t+Peff+1 onward.
- Periodic mode: matches occur every Peff cycles exactly, with no drift.
- A W1C write in cycle k drops irq_o in cycle k+1, unless a match occurs in cycle k.
- data_o reflects register contents in the same cycle as sel_i/addr_i (zero-wait read).

## Test plan
- One-shot, IE=1: PERIOD=10, then write CTRL=0x5 at count_i=100.
  - Required: irq_o rises in the cycle after count_i=110, SNAP=110, CTRL reads 0x4, state IDLE.
  - W1C STATUS drops irq_o next cycle; no further interrupt.
- Periodic: PERIOD=4, CTRL=0x7 at count_i=0.
  - Required: matches at 4, 8, 12, 16. SNAP follows each match.
  - Clearing PENDING between matches produces one irq_o pulse train per match.
- Wrap-around: PERIOD=8, arm at count_i=0xFFFFFFFC.
  - Required: match at count_i=0x00000004, SNAP=4.
- Collisions:
  - W1C in the same cycle as a match: PENDING remains 1.
  - CTRL EN=0 in the same cycle as a match: PENDING=1, state IDLE.
- Edge config:
  - PERIOD=0 arms with Peff=1: match on the next cycle.
  - IE=0 with PENDING=1: irq_o=0. Setting IE=1 raises irq_o next cycle.
  - sel_i=0: data_o=0 and writes are ignored.
- Reset mid-ARMED, 3 cycles before a match:
  - Required: no match occurs, all registers read 0, irq_o=0 from the cycle after reset.
